// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-side lookup, execute-side resolve feedback and statistics.
// The master drives queries and updates; the slave (predictor) returns predictions and counts.
interface branch_predictor_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] query_pc;
    logic                  predict_hit;
    logic                  predict_taken;
    logic [ADDR_WIDTH-1:0] predict_npc;
    logic                  update_valid;
    logic [ADDR_WIDTH-1:0] update_pc;
    logic                  update_taken;
    logic [ADDR_WIDTH-1:0] update_target;
    logic                  update_error;
    logic [31:0]           branch_count;
    logic [31:0]           mispredict_count;

    modport master (
        output query_pc, update_valid, update_pc, update_taken, update_target, update_error,
        input  predict_hit, predict_taken, predict_npc, branch_count, mispredict_count
    );

    modport slave (
        input  query_pc, update_valid, update_pc, update_taken, update_target, update_error,
        output predict_hit, predict_taken, predict_npc, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational; updates land on the clock edge with no bypass to the same-cycle lookup.
module branch_predictor #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_WIDTH = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    logic [ENTRIES-1:0]    valid;
    logic [TAG_BITS-1:0]   tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target [ENTRIES];
    logic [1:0]            ctr    [ENTRIES];
    logic [31:0]           branch_cnt;
    logic [31:0]           mispredict_cnt;

    logic [INDEX_BITS-1:0] q_idx, u_idx;
    logic [TAG_BITS-1:0]   q_tag, u_tag;
    logic                  q_hit, u_hit, accept;
    logic [1:0]            u_ctr, new_ctr;
    logic                  unused_pc_lsbs;

    assign q_idx = bp.query_pc[INDEX_BITS+1:2];
    assign q_tag = bp.query_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign u_idx = bp.update_pc[INDEX_BITS+1:2];
    assign u_tag = bp.update_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign unused_pc_lsbs = ^bp.update_pc[1:0];

    assign q_hit = valid[q_idx] && (tag[q_idx] == q_tag);
    assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);
    assign u_ctr = ctr[u_idx];
    assign accept = rdy_in && bp.update_valid;

    assign bp.predict_hit      = q_hit;
    assign bp.predict_taken    = q_hit && ctr[q_idx][1];
    assign bp.predict_npc      = bp.predict_taken ? target[q_idx] : bp.query_pc + ADDR_WIDTH'(4);
    assign bp.branch_count     = branch_cnt;
    assign bp.mispredict_count = mispredict_cnt;

    // A miss allocates weakly biased toward the observed outcome.
    always_comb begin
        new_ctr = bp.update_taken ? 2'b10 : 2'b01;
        if (u_hit)
            new_ctr = bp.update_taken ? ((u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'b01)
                                      : ((u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'b01);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid          <= '0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b01;
            end
        end else if (accept) begin
            valid[u_idx] <= 1'b1;
            tag[u_idx]   <= u_tag;
            ctr[u_idx]   <= new_ctr;
            if (!u_hit || bp.update_taken)
                target[u_idx] <= bp.update_target;
            branch_cnt <= branch_cnt + 32'd1;
            if (bp.update_error)
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus hand-written reset and counter-wrap sequences.
// Each vector is driven at the falling edge and checked before the following rising edge.
module tb_branch_predictor;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b0;

    branch_predictor_if #(.ADDR_WIDTH(32)) bp ();

    branch_predictor #(.INDEX_BITS(7), .ADDR_WIDTH(32)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bp     (bp)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        ue;
        logic [31:0] q;
        logic        hit;
        logic        tk;
        logic [31:0] npc;
        logic [31:0] bc;
        logic [31:0] mc;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [97:0] obs();
        return {bp.predict_hit, bp.predict_taken, bp.predict_npc, bp.branch_count, bp.mispredict_count};
    endfunction

    task automatic chk(input string nm, input logic [97:0] exp);
        logic [97:0] act;
        act = obs();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got hit=%b taken=%b npc=%h bc=%0d mc=%0d, expected hit=%b taken=%b npc=%h bc=%0d mc=%0d",
                     nm, act[97], act[96], act[95:64], act[63:32], act[31:0],
                     exp[97], exp[96], exp[95:64], exp[63:32], exp[31:0]);
        end
    endtask

    task automatic drive(input logic rdy, input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic ue, input logic [31:0] q);
        rdy_in           = rdy;
        bp.update_valid  = uv;
        bp.update_pc     = upc;
        bp.update_taken  = ut;
        bp.update_target = utgt;
        bp.update_error  = ue;
        bp.query_pc      = q;
    endtask

    initial begin
        // rdy uv upc ut utgt ue | q  hit tk npc bc mc  (outputs seen before this cycle's update)
        vt.push_back('{1, 0, 32'h0,    0, 32'h0,   0, 32'h100,  0, 0, 32'h104,  0,  0});
        vt.push_back('{1, 1, 32'h100,  1, 32'h80,  1, 32'h100,  0, 0, 32'h104,  0,  0});
        vt.push_back('{1, 1, 32'h100,  1, 32'h80,  0, 32'h100,  1, 1, 32'h80,   1,  1});
        vt.push_back('{1, 1, 32'h100,  1, 32'h80,  0, 32'h100,  1, 1, 32'h80,   2,  1});
        vt.push_back('{1, 1, 32'h100,  0, 32'h444, 0, 32'h100,  1, 1, 32'h80,   3,  1});
        vt.push_back('{1, 1, 32'h100,  0, 32'h444, 1, 32'h100,  1, 1, 32'h80,   4,  1});
        vt.push_back('{1, 1, 32'h100,  0, 32'h444, 0, 32'h100,  1, 0, 32'h104,  5,  2});
        vt.push_back('{1, 1, 32'h100,  0, 32'h444, 0, 32'h100,  1, 0, 32'h104,  6,  2});
        vt.push_back('{1, 1, 32'h100,  1, 32'h88,  0, 32'h100,  1, 0, 32'h104,  7,  2});
        vt.push_back('{1, 0, 32'h0,    0, 32'h0,   0, 32'h100,  1, 0, 32'h104,  8,  2});
        vt.push_back('{1, 1, 32'h100,  1, 32'h88,  0, 32'h100,  1, 0, 32'h104,  8,  2});
        vt.push_back('{1, 0, 32'h0,    0, 32'h0,   0, 32'h100,  1, 1, 32'h88,   9,  2});
        vt.push_back('{1, 1, 32'h300,  1, 32'h40,  0, 32'h300,  0, 0, 32'h304,  9,  2});
        vt.push_back('{1, 0, 32'h0,    0, 32'h0,   0, 32'h100,  0, 0, 32'h104, 10,  2});
        vt.push_back('{1, 0, 32'h0,    0, 32'h0,   0, 32'h300,  1, 1, 32'h40,  10,  2});
        vt.push_back('{1, 1, 32'h100,  0, 32'h20,  1, 32'h100,  0, 0, 32'h104, 10,  2});
        vt.push_back('{1, 0, 32'h0,    0, 32'h0,   0, 32'h100,  1, 0, 32'h104, 11,  3});
        vt.push_back('{1, 1, 32'h1007, 1, 32'hABC, 0, 32'h1004, 0, 0, 32'h1008, 11,  3});
        vt.push_back('{1, 0, 32'h0,    0, 32'h0,   0, 32'h1004, 1, 1, 32'hABC, 12,  3});
        vt.push_back('{1, 0, 32'h0,    0, 32'h0,   0, 32'hFFFFFFFC, 0, 0, 32'h0, 12, 3});
        vt.push_back('{0, 1, 32'h100,  1, 32'h30,  1, 32'h100,  1, 0, 32'h104, 12,  3});
        vt.push_back('{1, 0, 32'h0,    0, 32'h0,   0, 32'h100,  1, 0, 32'h104, 12,  3});
        vt.push_back('{1, 1, 32'h100,  1, 32'h60,  0, 32'h100,  1, 0, 32'h104, 12,  3});
        vt.push_back('{1, 1, 32'h100,  0, 32'h0,   1, 32'h100,  1, 1, 32'h60,  13,  3});
        vt.push_back('{1, 0, 32'h0,    0, 32'h0,   0, 32'h100,  1, 0, 32'h104, 14,  4});

        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h100);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;

        foreach (vt[k]) begin
            @(negedge clk_in);
            drive(vt[k].rdy, vt[k].uv, vt[k].upc, vt[k].ut, vt[k].utgt, vt[k].ue, vt[k].q);
            #1;
            chk($sformatf("vec%0d", k), {vt[k].hit, vt[k].tk, vt[k].npc, vt[k].bc, vt[k].mc});
        end

        // Reset lands between edges while an update is pending; outputs must drop at once.
        @(negedge clk_in);
        drive(1, 1, 32'h300, 1, 32'h40, 1, 32'h1004);
        #1 chk("pre_reset", {1'b1, 1'b1, 32'hABC, 32'd14, 32'd4});
        #1 rst_in = 1'b1;
        #1 chk("async_reset", {1'b0, 1'b0, 32'h1008, 32'd0, 32'd0});
        @(negedge clk_in);
        drive(1, 0, 32'h0, 0, 32'h0, 0, 32'h300);
        rst_in = 1'b0;
        #1 chk("update_lost", {1'b0, 1'b0, 32'h304, 32'd0, 32'd0});

        // Counter wrap from all-ones.
        @(negedge clk_in);
        force dut.branch_cnt = 32'hFFFF_FFFF;
        #1 release dut.branch_cnt;
        drive(1, 1, 32'h100, 1, 32'h80, 1, 32'h100);
        #1 chk("pre_wrap", {1'b0, 1'b0, 32'h104, 32'hFFFF_FFFF, 32'd0});
        @(negedge clk_in);
        drive(1, 0, 32'h0, 0, 32'h0, 0, 32'h100);
        #1 chk("wrap", {1'b1, 1'b1, 32'h80, 32'd0, 32'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- Feeds the fetch stage a per-PC taken prediction and next-PC for each fetched instruction.
- Consumes the resolved-branch feedback that the execute stage emits: update strobe, branch PC, actual outcome, resolved next-PC and mispredict flag.
- Keeps running branch and mispredict statistics for performance counting.

Parameters:
- INDEX_BITS, 7, log2 of entry count (128 entries); index = pc[INDEX_BITS+1:2].
- ADDR_WIDTH, 32, instruction address width.

Ports:
- clk_in  input  1  clock, all state updates on rising edge
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  global ready; when low, no table or counter state changes
- query_pc  input  ADDR_WIDTH  PC being fetched this cycle
- predict_hit  output  1  valid entry with matching tag for query_pc
- predict_taken  output  1  prediction that query_pc branches
- predict_npc  output  ADDR_WIDTH  predicted next PC
- update_valid  input  1  resolved branch/jump present (execute-stage predict_update)
- update_pc  input  ADDR_WIDTH  PC of resolved instruction
- update_taken  input  1  actual outcome; 1 for jumps
- update_target  input  ADDR_WIDTH  resolved next PC
- update_error  input  1  execute stage flagged a mispredict
- branch_count  output  32  accepted updates since reset
- mispredict_count  output  32  accepted updates with update_error=1 since reset

Behaviour:
- Entry fields:
  - valid (1)
  - tag = pc[ADDR_WIDTH-1:INDEX_BITS+2]
  - target (ADDR_WIDTH)
  - ctr (2)
- Lookup is combinational from query_pc and current table state, with zero latency:
  - hit = valid & tag match.
  - taken = hit & ctr[1].
  - npc = taken ? target : query_pc+4. The addition wraps modulo 2^ADDR_WIDTH.
- Accepted update: on a rising edge with update_valid=1, rdy_in=1 and rst_in=0. It acts on entry idx(update_pc).
- Hit update (valid & tag match):
  - If update_taken, ctr saturating-increments (max 11) and target <= update_target.
  - Otherwise ctr saturating-decrements (min 00) and target is unchanged.
- Miss update (invalid entry or tag mismatch) allocates the entry, replacing any alias unconditionally:
  - valid <= 1.
  - tag <= update_pc tag.
  - target <= update_target.
  - ctr <= update_taken ? 10 : 01.
- Counters:
  - branch_count += 1 per accepted update.
  - mispredict_count += 1 when the accepted update also has update_error=1.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Same-cycle update and query of the same index: lookup returns the pre-update contents. There is no bypass; the new contents are visible from the next cycle.
- update_pc[1:0] is ignored.
- rdy_in=0 or update_valid=0: all state holds. Lookup outputs remain live.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits <= 0, ctr <= 01, target <= 0.
  - branch_count <= 0 and mispredict_count <= 0.
  - Resulting outputs: predict_hit=0, predict_taken=0, predict_npc=query_pc+4.
  - An update coincident with reset is discarded.
- Table is register- or distributed-RAM-based. Async reset of all valid bits is mandatory.

Test Plan:
- Reset, then query_pc=0x100 -> hit=0, taken=0, npc=0x104; both counts 0.
- Update (pc=0x100, taken=1, target=0x80, error=1), then query 0x100 the next cycle -> hit=1, taken=1, npc=0x80; branch_count=1, mispredict_count=1.
- From that entry (ctr=10), apply two more taken updates (ctr=11), then one not-taken -> still taken (ctr=10). A second not-taken -> taken=0, npc=0x104. Two more not-taken -> ctr saturates at 00. One taken -> ctr=01, still not taken.
- Aliasing: allocate 0x100 (taken, target 0x80), then update pc=0x300 (taken, target 0x40), same index with a different tag -> query 0x100 gives hit=0, npc=0x104; query 0x300 gives hit=1, npc=0x40.
- Same-cycle conflict and freeze:
  - With an entry at 0x100, query 0x100 in the same cycle as a not-taken update to 0x100 -> output shows the old prediction that cycle and the updated one the next cycle.
  - Repeat the update with rdy_in=0 -> no change to the entry or the counts.
- Assert rst_in asynchronously mid-cycle after several updates -> outputs drop to the reset values immediately, without waiting for a clock edge; the coincident update is lost.
- Counter wrap: force branch_count to 0xFFFFFFFF, then one accepted update -> branch_count=0.
